// File: rtl/ariane_pkg.sv
// AMO request/response types exchanged between the LSU AMO buffer and the cache.
package ariane_pkg;
   typedef enum logic [3:0] {
      AMO_NONE,
      AMO_LR,
      AMO_SC,
      AMO_SWAP,
      AMO_ADD,
      AMO_AND,
      AMO_OR,
      AMO_XOR,
      AMO_MAX,
      AMO_MAXU,
      AMO_MIN,
      AMO_MINU,
      AMO_CAS1,
      AMO_CAS2
   } amo_t;

   typedef struct packed {
      logic        req;
      amo_t        amo_op;
      logic [1:0]  size;
      logic [63:0] operand_a;
      logic [63:0] operand_b;
      logic        aq;
      logic        rl;
   } amo_req_t;

   typedef struct packed {
      logic        ack;
      logic [63:0] result;
   } amo_resp_t;
endpackage

// File: rtl/riscv.sv
// Physical address width shared by the cache subsystem.
package riscv;
   localparam int unsigned PLEN = 56;
endpackage

// File: rtl/amo_rmw_unit.sv
// AMO responder: runs one atomic op as a read-modify-write on a 64-bit req/gnt
// memory port, tracks the single LR/SC reservation and returns the old value.
module amo_rmw_unit
   import ariane_pkg::*;
(
   input  logic                   clk_i,
   input  logic                   rst_i,
   input  amo_req_t               amo_req_i,
   output amo_resp_t              amo_resp_o,
   output logic                   mem_req_o,
   output logic                   mem_we_o,
   output logic [riscv::PLEN-1:0] mem_addr_o,
   output logic [63:0]            mem_wdata_o,
   output logic [7:0]             mem_be_o,
   input  logic                   mem_gnt_i,
   input  logic                   mem_rvalid_i,
   input  logic [63:0]            mem_rdata_i
);

   localparam int unsigned PLEN = riscv::PLEN;

   typedef enum logic [2:0] {StIdle, StRd, StRdWait, StWr, StWrWait, StResp} state_t;

   state_t            state_q;
   amo_t              op_q;
   logic              word_q;
   logic [PLEN-1:2]   addr_q;
   logic [63:0]       opb_q;
   logic [63:0]       wdata_q;
   logic [7:0]        be_q;
   logic              mem_req_q;
   logic              mem_we_q;
   logic              ack_q;
   logic [63:0]       result_q;
   logic              resv_valid_q;
   logic [PLEN-1:3]   resv_addr_q;

   // Request-side decode used at capture time
   logic              req_word;
   logic [PLEN-1:0]   req_addr;
   logic [7:0]        req_be;
   logic [63:0]       sc_wdata;
   logic              resv_hit;

   // Read-side datapath: old value and computed new value
   logic [31:0]       old_w;
   logic [63:0]       old_val;
   logic [63:0]       opnd;
   logic [63:0]       new_val;
   logic [63:0]       new_wdata;
   logic [7:0]        lane_be;

   // aq/rl carry no meaning here; the unit only ever has one op in flight
   logic              unused_ok;
   assign unused_ok = ^{amo_req_i.aq, amo_req_i.rl, amo_req_i.operand_a[63:PLEN],
                        amo_req_i.operand_a[1:0]};

   // Decode the incoming request for capture in IDLE
   always_comb begin
      req_word = (amo_req_i.size == 2'b10);
      req_addr = amo_req_i.operand_a[PLEN-1:0];
      req_be   = req_word ? (req_addr[2] ? 8'hF0 : 8'h0F) : 8'hFF;
      sc_wdata = req_word ? {amo_req_i.operand_b[31:0], amo_req_i.operand_b[31:0]}
                          : amo_req_i.operand_b;
      resv_hit = resv_valid_q && (resv_addr_q == req_addr[PLEN-1:3]);
   end

   // Compute the new memory value from read data and the captured operand.
   // Word operands are sign-extended so one 64-bit compare serves both widths.
   always_comb begin
      old_w   = addr_q[2] ? mem_rdata_i[63:32] : mem_rdata_i[31:0];
      old_val = word_q ? {{32{old_w[31]}}, old_w} : mem_rdata_i;
      opnd    = word_q ? {{32{opb_q[31]}}, opb_q[31:0]} : opb_q;
      case (op_q)
         AMO_ADD:  new_val = old_val + opnd;
         AMO_AND:  new_val = old_val & opnd;
         AMO_OR:   new_val = old_val | opnd;
         AMO_XOR:  new_val = old_val ^ opnd;
         AMO_MAX:  new_val = ($signed(old_val) > $signed(opnd)) ? old_val : opnd;
         AMO_MIN:  new_val = ($signed(old_val) < $signed(opnd)) ? old_val : opnd;
         AMO_MAXU: new_val = (old_val > opnd) ? old_val : opnd;
         AMO_MINU: new_val = (old_val < opnd) ? old_val : opnd;
         default:  new_val = opnd;
      endcase
      new_wdata = word_q ? {new_val[31:0], new_val[31:0]} : new_val;
      lane_be   = word_q ? (addr_q[2] ? 8'hF0 : 8'h0F) : 8'hFF;
   end

   // Sequencer FSM with registered memory-port and response outputs
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q      <= StIdle;
         op_q         <= AMO_NONE;
         word_q       <= 1'b0;
         addr_q       <= '0;
         opb_q        <= '0;
         wdata_q      <= '0;
         be_q         <= '0;
         mem_req_q    <= 1'b0;
         mem_we_q     <= 1'b0;
         ack_q        <= 1'b0;
         result_q     <= '0;
         resv_valid_q <= 1'b0;
         resv_addr_q  <= '0;
      end else begin
         ack_q <= 1'b0;
         case (state_q)
            StIdle: begin
               if (amo_req_i.req) begin
                  op_q   <= amo_req_i.amo_op;
                  word_q <= req_word;
                  addr_q <= req_addr[PLEN-1:2];
                  opb_q  <= amo_req_i.operand_b;
                  case (amo_req_i.amo_op)
                     AMO_SC: begin
                        // Every SC consumes the reservation, pass or fail
                        resv_valid_q <= 1'b0;
                        if (resv_hit) begin
                           wdata_q   <= sc_wdata;
                           be_q      <= req_be;
                           result_q  <= 64'd0;
                           mem_req_q <= 1'b1;
                           mem_we_q  <= 1'b1;
                           state_q   <= StWr;
                        end else begin
                           result_q <= 64'd1;
                           ack_q    <= 1'b1;
                           state_q  <= StResp;
                        end
                     end
                     AMO_CAS1, AMO_CAS2, AMO_NONE: begin
                        result_q <= 64'd0;
                        ack_q    <= 1'b1;
                        state_q  <= StResp;
                     end
                     default: begin
                        be_q      <= 8'hFF;
                        mem_req_q <= 1'b1;
                        mem_we_q  <= 1'b0;
                        state_q   <= StRd;
                     end
                  endcase
               end
            end
            StRd: begin
               if (mem_gnt_i) begin
                  mem_req_q <= 1'b0;
                  state_q   <= StRdWait;
               end
            end
            StRdWait: begin
               if (mem_rvalid_i) begin
                  result_q <= old_val;
                  if (op_q == AMO_LR) begin
                     resv_valid_q <= 1'b1;
                     resv_addr_q  <= addr_q[PLEN-1:3];
                     ack_q        <= 1'b1;
                     state_q      <= StResp;
                  end else begin
                     wdata_q   <= new_wdata;
                     be_q      <= lane_be;
                     mem_req_q <= 1'b1;
                     mem_we_q  <= 1'b1;
                     state_q   <= StWr;
                  end
               end
            end
            StWr: begin
               if (mem_gnt_i) begin
                  mem_req_q <= 1'b0;
                  mem_we_q  <= 1'b0;
                  state_q   <= StWrWait;
               end
            end
            StWrWait: begin
               if (mem_rvalid_i) begin
                  // A completed store into the reserved granule breaks the reservation
                  if (resv_addr_q == addr_q[PLEN-1:3]) begin
                     resv_valid_q <= 1'b0;
                  end
                  ack_q   <= 1'b1;
                  state_q <= StResp;
               end
            end
            StResp: begin
               state_q <= StIdle;
            end
            default: begin
               state_q <= StIdle;
            end
         endcase
      end
   end

   assign mem_req_o         = mem_req_q;
   assign mem_we_o          = mem_we_q;
   assign mem_addr_o        = {addr_q[PLEN-1:3], 3'b000};
   assign mem_wdata_o       = wdata_q;
   assign mem_be_o          = be_q;
   assign amo_resp_o.ack    = ack_q;
   assign amo_resp_o.result = result_q;

endmodule

// File: tb/tb_amo_rmw_unit.sv
// Directed bench for amo_rmw_unit with a byte-enabled memory model that can stall reads.
module tb_amo_rmw_unit;
   import ariane_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   amo_req_t    amo_req;
   amo_resp_t   amo_resp;
   logic        mem_req;
   logic        mem_we;
   logic [55:0] mem_addr;
   logic [63:0] mem_wdata;
   logic [7:0]  mem_be;
   logic        mem_gnt;
   logic        mem_rvalid = 1'b0;
   logic [63:0] mem_rdata = '0;

   logic [63:0] mem [4096];
   int          stall_len = 0;
   int          stall_cnt = 0;
   int          rd_cnt = 0;
   int          wr_cnt = 0;
   int          unstable = 0;
   logic [63:0] last_wdata = '0;
   logic [7:0]  last_be = '0;
   logic        prev_wait = 1'b0;
   logic [55:0] prev_addr = '0;
   logic [7:0]  prev_be = '0;
   logic        poke_en = 1'b0;
   logic [11:0] poke_idx = '0;
   logic [63:0] poke_val = '0;

   int          n_tests = 0;
   int          n_fail = 0;

   amo_rmw_unit dut (
      .clk_i       (clk),
      .rst_i       (rst),
      .amo_req_i   (amo_req),
      .amo_resp_o  (amo_resp),
      .mem_req_o   (mem_req),
      .mem_we_o    (mem_we),
      .mem_addr_o  (mem_addr),
      .mem_wdata_o (mem_wdata),
      .mem_be_o    (mem_be),
      .mem_gnt_i   (mem_gnt),
      .mem_rvalid_i(mem_rvalid),
      .mem_rdata_i (mem_rdata)
   );

   always #5 clk = ~clk;

   // Reads may be held off for stall_len cycles; writes are granted at once
   assign mem_gnt = mem_req && (mem_we || stall_cnt >= stall_len);

   function automatic logic [63:0] merge(input logic [63:0] old, input logic [63:0] nw,
                                         input logic [7:0] be);
      logic [63:0] r;
      r = old;
      for (int b = 0; b < 8; b++) if (be[b]) r[8*b +: 8] = nw[8*b +: 8];
      return r;
   endfunction

   // Memory model: rvalid one cycle after gnt, returning pre-write contents
   always @(posedge clk) begin
      mem_rvalid <= 1'b0;
      if (poke_en) mem[poke_idx] <= poke_val;
      if (mem_req && !mem_gnt) stall_cnt <= stall_cnt + 1;
      if (mem_req && mem_gnt) begin
         stall_cnt  <= 0;
         mem_rvalid <= 1'b1;
         mem_rdata  <= mem[mem_addr[14:3]];
         if (mem_we) begin
            mem[mem_addr[14:3]] <= merge(mem[mem_addr[14:3]], mem_wdata, mem_be);
            wr_cnt     <= wr_cnt + 1;
            last_wdata <= mem_wdata;
            last_be    <= mem_be;
         end else begin
            rd_cnt <= rd_cnt + 1;
         end
      end
      if (mem_req && !mem_gnt) begin
         if (prev_wait && (mem_addr != prev_addr || mem_be != prev_be)) unstable <= unstable + 1;
         prev_wait <= 1'b1;
         prev_addr <= mem_addr;
         prev_be   <= mem_be;
      end else begin
         prev_wait <= 1'b0;
      end
   end

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic poke(input logic [63:0] addr, input logic [63:0] val);
      @(negedge clk);
      poke_en  = 1'b1;
      poke_idx = addr[14:3];
      poke_val = val;
      @(negedge clk);
      poke_en = 1'b0;
   endtask

   // Issue one request; lat counts cycles from the sampling edge to the ack cycle
   task automatic do_amo(input amo_t op, input logic [1:0] sz, input logic [63:0] a,
                         input logic [63:0] b, output logic [63:0] res, output int lat);
      logic got_ack;
      @(negedge clk);
      amo_req.req       = 1'b1;
      amo_req.amo_op    = op;
      amo_req.size      = sz;
      amo_req.operand_a = a;
      amo_req.operand_b = b;
      @(posedge clk);
      lat     = 0;
      res     = '0;
      got_ack = 1'b0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         lat++;
         if (amo_resp.ack) begin
            res     = amo_resp.result;
            got_ack = 1'b1;
            break;
         end
      end
      amo_req.req = 1'b0;
      if (!got_ack) check_eq("ack_timeout", {63'd0, got_ack}, 64'd1);
      @(negedge clk);
      check_eq("ack_pulse", {63'd0, amo_resp.ack}, 64'd0);
   endtask

   initial begin
      logic [63:0] res;
      int          lat;
      int          wr0;
      int          rd0;

      rst     = 1'b1;
      amo_req = '0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check_eq("rst_ack", {63'd0, amo_resp.ack}, 64'd0);
      check_eq("rst_result", amo_resp.result, 64'd0);
      check_eq("rst_mem_req", {63'd0, mem_req}, 64'd0);
      check_eq("rst_mem_we", {63'd0, mem_we}, 64'd0);

      // Dword ADD
      poke(64'h1000, 64'd5);
      do_amo(AMO_ADD, 2'b11, 64'h1000, 64'd3, res, lat);
      check_eq("dadd_result", res, 64'd5);
      check_eq("dadd_lat", 64'(lat), 64'd5);
      check_eq("dadd_wdata", last_wdata, 64'd8);
      check_eq("dadd_be", {56'd0, last_be}, 64'hFF);
      check_eq("dadd_mem", mem[12'h200], 64'd8);

      // Word ADD, upper lane
      poke(64'h1000, 64'h0000_0005_FFFF_FFFF);
      do_amo(AMO_ADD, 2'b10, 64'h1004, 64'd3, res, lat);
      check_eq("wadd_result", res, 64'd5);
      check_eq("wadd_be", {56'd0, last_be}, 64'hF0);
      check_eq("wadd_wdata_hi", {32'd0, last_wdata[63:32]}, 64'd8);
      check_eq("wadd_mem", mem[12'h200], 64'h0000_0008_FFFF_FFFF);

      // Word MAX (signed) vs MAXU
      poke(64'h2000, 64'h0000_0000_FFFF_FFFF);
      do_amo(AMO_MAX, 2'b10, 64'h2000, 64'd1, res, lat);
      check_eq("wmax_result", res, 64'hFFFF_FFFF_FFFF_FFFF);
      check_eq("wmax_be", {56'd0, last_be}, 64'h0F);
      check_eq("wmax_mem", mem[12'h400], 64'h0000_0000_0000_0001);
      poke(64'h2000, 64'h0000_0000_FFFF_FFFF);
      do_amo(AMO_MAXU, 2'b10, 64'h2000, 64'd1, res, lat);
      check_eq("wmaxu_result", res, 64'hFFFF_FFFF_FFFF_FFFF);
      check_eq("wmaxu_wdata_lo", {32'd0, last_wdata[31:0]}, 64'hFFFF_FFFF);
      check_eq("wmaxu_mem", mem[12'h400], 64'h0000_0000_FFFF_FFFF);

      // LR / SC pair, then a repeated SC that must fail
      poke(64'h3000, 64'h1122_3344_5566_7788);
      wr0 = wr_cnt;
      do_amo(AMO_LR, 2'b11, 64'h3000, 64'd0, res, lat);
      check_eq("lr_result", res, 64'h1122_3344_5566_7788);
      check_eq("lr_lat", 64'(lat), 64'd3);
      check_eq("lr_no_write", 64'(wr_cnt - wr0), 64'd0);
      do_amo(AMO_SC, 2'b11, 64'h3000, 64'hAB, res, lat);
      check_eq("sc_ok_result", res, 64'd0);
      check_eq("sc_ok_lat", 64'(lat), 64'd3);
      check_eq("sc_ok_mem", mem[12'h600], 64'hAB);
      wr0 = wr_cnt;
      rd0 = rd_cnt;
      do_amo(AMO_SC, 2'b11, 64'h3000, 64'hCD, res, lat);
      check_eq("sc_rep_result", res, 64'd1);
      check_eq("sc_rep_lat", 64'(lat), 64'd1);
      check_eq("sc_rep_no_mem", 64'((wr_cnt - wr0) + (rd_cnt - rd0)), 64'd0);

      // Reservation killed by a store to the same granule
      do_amo(AMO_LR, 2'b11, 64'h3000, 64'd0, res, lat);
      check_eq("lr2_result", res, 64'hAB);
      do_amo(AMO_SWAP, 2'b10, 64'h3004, 64'h77, res, lat);
      check_eq("swap_result", res, 64'd0);
      check_eq("swap_mem", mem[12'h600], 64'h0000_0077_0000_00AB);
      wr0 = wr_cnt;
      do_amo(AMO_SC, 2'b11, 64'h3000, 64'hCD, res, lat);
      check_eq("sc_kill_result", res, 64'd1);
      check_eq("sc_kill_no_write", 64'(wr_cnt - wr0), 64'd0);
      check_eq("sc_kill_mem", mem[12'h600], 64'h0000_0077_0000_00AB);

      // Read stalled 4 cycles
      poke(64'h1000, 64'd8);
      stall_len = 4;
      do_amo(AMO_XOR, 2'b11, 64'h1000, 64'hF, res, lat);
      stall_len = 0;
      check_eq("stall_result", res, 64'd8);
      check_eq("stall_lat", 64'(lat), 64'd9);
      check_eq("stall_stable", 64'(unstable), 64'd0);
      check_eq("stall_mem", mem[12'h200], 64'd7);

      // CAS is answered without touching memory
      rd0 = rd_cnt;
      wr0 = wr_cnt;
      do_amo(AMO_CAS1, 2'b11, 64'h1000, 64'h1, res, lat);
      check_eq("cas_result", res, 64'd0);
      check_eq("cas_lat", 64'(lat), 64'd1);
      check_eq("cas_no_mem", 64'((wr_cnt - wr0) + (rd_cnt - rd0)), 64'd0);

      // Reset during WR_WAIT of a SWAP after an LR
      do_amo(AMO_LR, 2'b11, 64'h3000, 64'd0, res, lat);
      @(negedge clk);
      amo_req.req       = 1'b1;
      amo_req.amo_op    = AMO_SWAP;
      amo_req.size      = 2'b11;
      amo_req.operand_a = 64'h3008;
      amo_req.operand_b = 64'h55;
      @(posedge clk);
      repeat (3) @(negedge clk);
      check_eq("rst_in_wr", {62'd0, mem_req, mem_we}, 64'd3);
      @(negedge clk);
      rst         = 1'b1;
      amo_req.req = 1'b0;
      @(negedge clk);
      check_eq("rst_mid_ack", {63'd0, amo_resp.ack}, 64'd0);
      check_eq("rst_mid_req", {63'd0, mem_req}, 64'd0);
      rst = 1'b0;
      @(negedge clk);
      check_eq("rst_after_ack", {63'd0, amo_resp.ack}, 64'd0);
      wr0 = wr_cnt;
      do_amo(AMO_SC, 2'b11, 64'h3000, 64'h99, res, lat);
      check_eq("rst_sc_result", res, 64'd1);
      check_eq("rst_sc_lat", 64'(lat), 64'd1);
      check_eq("rst_sc_no_write", 64'(wr_cnt - wr0), 64'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/amo_rmw_unit.md
# amo_rmw_unit

Cache-side responder for the atomic memory operation request/response interface. It accepts one `ariane_pkg::amo_req_t` at a time from the load/store unit's AMO buffer. It executes the operation as a read-modify-write sequence on a 64-bit request/grant memory port of the data cache, maintains the single LR/SC reservation, and returns the old memory value through `ariane_pkg::amo_resp_t`. It sits inside the cache subsystem, between the AMO request bus and the D$ memory arbiter.

## Interface
- Parameters: none. Address width is `riscv::PLEN`.

Ports:
- `clk_i` in 1: clock.
- `rst_i` in 1: synchronous reset, active-high.
- `amo_req_i` in `amo_req_t`: fields req, amo_op, size (2'b10 word, 2'b11 dword), operand_a (address), operand_b (data), aq, rl.
- `amo_resp_o` out `amo_resp_t`: ack (one-cycle pulse) and result [63:0].
- `mem_req_o` out 1: memory request.
- `mem_we_o` out 1: 1 = write.
- `mem_addr_o` out PLEN: address, dword-aligned (`operand_a[PLEN-1:3]`, 3'b0).
- `mem_wdata_o` out 64: write data.
- `mem_be_o` out 8: byte enables.
- `mem_gnt_i` in 1: request accepted.
- `mem_rvalid_i` in 1: read data valid, or write complete. Arrives at least 1 cycle after gnt.
- `mem_rdata_i` in 64: read data.

## Operation
- FSM states: IDLE, RD, RD_WAIT, WR, WR_WAIT, RESP.
- IDLE: when `amo_req_i.req` is 1, register op, size, address, operand_b. Next state by op:
  - AMO_SC with valid matching reservation: WR.
  - AMO_SC otherwise (fail): RESP, result = 1.
  - AMO_CAS1, AMO_CAS2, AMO_NONE: RESP, result = 0, no memory access.
  - All other ops: RD.
- RD: `mem_req_o=1`, `we=0`, `be=8'hFF`. Go to RD_WAIT on gnt.
- RD_WAIT: on rvalid, register rdata. Next state:
  - AMO_LR: RESP. Also set reservation = {valid, addr[PLEN-1:3]}.
  - Otherwise: WR.
- WR: `mem_req_o=1`, `we=1`. Go to WR_WAIT on gnt.
- WR_WAIT: go to RESP on rvalid.
- RESP: ack=1 for exactly one cycle, then IDLE.
- `mem_addr_o`, `mem_wdata_o` and `mem_be_o` are held stable while `mem_req_o` is high and gnt is low.
- Operands are registered at capture. Changes on `amo_req_i` while not in IDLE are ignored.
- Word operations (size 2'b10):
  - lane = addr[2]. Old value = rdata[32*lane +: 32]. Operand = operand_b[31:0].
  - wdata = {new, new}. be = lane ? 8'hF0 : 8'h0F.
  - result = old value sign-extended to 64 bits.
- Dword operations: full 64 bits, `be=8'hFF`.
- New value per op (all arithmetic at operand width, wrap-around, no overflow flag):
  - SWAP: operand.
  - ADD: old + operand.
  - AND, OR, XOR: bitwise.
  - MAX/MIN: signed compare.
  - MAXU/MINU: unsigned compare.
  - SC: operand.
- SC: successful SC returns result 0. Every SC, successful or failed, clears the reservation.
- Any completed write (any AMO, including SC) to the reserved granule clears the reservation.
- A new LR overwrites the reservation.
- aq/rl are accepted but have no effect: the unit is already fully serialized.
- Reset:
  - Outputs: state IDLE, `mem_req_o=0`, `mem_we_o=0`, `ack=0`, `result=0`.
  - Reservation invalid.
  - Reset mid-operation abandons the sequence at that edge. No ack is issued. `mem_req_o` is low the cycle after the reset edge.

## Timing
- Req sampled in IDLE at cycle N. Best case is gnt in the request cycle and rvalid one cycle after gnt.
- RMW ops (SWAP/ADD/logic/MIN/MAX): RD at N+1, RD_WAIT at N+2, WR at N+3, WR_WAIT at N+4, ack at N+5.
- LR: ack at N+3.
- SC success: WR at N+1, ack at N+3.
- SC fail or CAS: ack at N+1.
- Each cycle without gnt or rvalid adds one cycle.
- `amo_req_i.req` drops the cycle after ack, because the requester pops on ack. Back-to-back requests therefore see at least one IDLE cycle.
- `amo_resp_o.result` is valid only in the ack cycle. It is registered and driven from flops.

## Test plan
- Dword ADD: addr 0x1000, mem 0x0000_0000_0000_0005, operand_b 3. Required: read then write wdata 0x…08, be 8'hFF; result 5; ack at N+5.
- Word ADD, upper lane: addr 0x1004, mem 0x0000_0005_FFFF_FFFF, operand_b 3. Required: wdata upper word 0x0000_0008, be 8'hF0; result 5; lower word untouched.
- Word MAX vs MAXU: addr 0x2000, low word 0xFFFF_FFFF, operand_b 1.
  - MAX: writes 1; result 0xFFFF_FFFF_FFFF_FFFF.
  - MAXU: writes 0xFFFF_FFFF.
- LR/SC pair: LR at 0x3000 returns mem value, no write. SC at 0x3000 with data 0xAB: write 0xAB, result 0. Repeat SC: no memory access, result 1, ack at N+1.
- Reservation kill: LR at 0x3000, then SWAP at 0x3004, then SC at 0x3000. Required: SC result 1, no write.
- Stalls and reset: hold gnt low for 4 cycles in RD. Required: `mem_addr_o`/`be` stable and ack delayed by 4 cycles. Assert `rst_i` while in WR_WAIT. Required: no ack, `mem_req_o=0` the next cycle, a following SC fails.
